// File: rtl/mixer_audio_pll_pkg.sv
// rtl/mixer_audio_pll_pkg.sv - shared types and default timing constants for the audio PLL sequencer
package mixer_audio_pll_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL,
    ST_WAIT_LOCK,
    ST_STABLE_CHECK,
    ST_RUN,
    ST_FAULT
  } pll_state_t;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRIES   = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mixer_sync2.sv
// rtl/mixer_sync2.sv - generic two-flop synchronizer, flops clear to 0 on reset
module mixer_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mixer_audio_pll_sequencer.sv
// rtl/mixer_audio_pll_sequencer.sv - resets the audio PLL, waits for a stable lock, releases the audio domain
module mixer_audio_pll_sequencer
  import mixer_audio_pll_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       audio_reset_n,
  output logic       pll_ok,
  output logic       fault,
  output logic [1:0] retry_count,
  output logic [7:0] lock_loss_count
);

  localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t       RST_LAST     = cnt_t'(RST_CYCLES - 1);
  localparam cnt_t       TIMEOUT_LAST = cnt_t'(LOCK_TIMEOUT - 1);
  localparam cnt_t       STABLE_LAST  = cnt_t'(STABLE_CYCLES - 1);
  localparam logic [1:0] RETRY_LIMIT  = 2'(MAX_RETRIES);

  pll_state_t state, state_d;
  cnt_t       cnt, cnt_d;
  logic [1:0] retry_d;
  logic [1:0] retry_inc;
  logic [7:0] llc_d;
  logic       lock_s;
  logic       lost;
  logic       pll_rst_d, audio_reset_n_d, pll_ok_d, fault_d;

  mixer_sync2 #(.WIDTH(1)) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (lock_s)
  );

  assign retry_inc = retry_count + 2'd1;
  assign lost      = (state == ST_RUN) && !lock_s;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= ST_RESET_PLL;
      cnt             <= '0;
      retry_count     <= '0;
      lock_loss_count <= '0;
      pll_rst         <= 1'b1;
      audio_reset_n   <= 1'b0;
      pll_ok          <= 1'b0;
      fault           <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      retry_count     <= retry_d;
      lock_loss_count <= llc_d;
      pll_rst         <= pll_rst_d;
      audio_reset_n   <= audio_reset_n_d;
      pll_ok          <= pll_ok_d;
      fault           <= fault_d;
    end
  end

  // A lock loss is counted even when a restart lands on the same cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    retry_d = retry_count;
    llc_d   = lock_loss_count;
    if (lost && (lock_loss_count != 8'hFF)) begin
      llc_d = lock_loss_count + 8'd1;
    end
    if (restart) begin
      state_d = ST_RESET_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state)
        ST_RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + cnt_t'(1);
          end
        end
        ST_WAIT_LOCK: begin
          if (lock_s) begin
            state_d = ST_STABLE_CHECK;
            cnt_d   = '0;
          end else if (cnt == TIMEOUT_LAST) begin
            retry_d = retry_inc;
            cnt_d   = '0;
            state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_RESET_PLL;
          end else begin
            cnt_d = cnt + cnt_t'(1);
          end
        end
        ST_STABLE_CHECK: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt + cnt_t'(1);
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
          end
        end
        ST_FAULT: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_RESET_PLL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_comb begin
    pll_rst_d       = (state_d == ST_RESET_PLL) || (state_d == ST_FAULT);
    audio_reset_n_d = (state_d == ST_RUN);
    pll_ok_d        = (state_d == ST_RUN);
    fault_d         = (state_d == ST_FAULT);
  end

endmodule

// File: tb/tb_mixer_audio_pll_sequencer.sv
// tb/tb_mixer_audio_pll_sequencer.sv - self-checking bench for the audio PLL sequencer
`timescale 1ns/1ps
module tb_mixer_audio_pll_sequencer;

  localparam int RST  = 4;
  localparam int TO   = 100;
  localparam int STAB = 16;
  localparam int ATT  = RST + TO;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       audio_reset_n;
  logic       pll_ok;
  logic       fault;
  logic [1:0] retry_count;
  logic [7:0] lock_loss_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;

  always #10 clk = ~clk;

  mixer_audio_pll_sequencer #(
    .RST_CYCLES    (RST),
    .LOCK_TIMEOUT  (TO),
    .STABLE_CYCLES (STAB),
    .MAX_RETRIES   (2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .restart         (restart),
    .pll_rst         (pll_rst),
    .audio_reset_n   (audio_reset_n),
    .pll_ok          (pll_ok),
    .fault           (fault),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count)
  );

  // Expected synchronized lock: h1 is lock_s this cycle, h2 is lock_s last cycle.
  always @(posedge clk) begin
    h0 <= reset_n ? pll_locked : 1'b0;
    h1 <= reset_n ? h0 : 1'b0;
    h2 <= h1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic e_rst, input logic e_run,
                          input logic e_flt, input int e_retry, input int e_llc);
    chk({tag, ".pll_rst"}, pll_rst, e_rst);
    chk({tag, ".audio_reset_n"}, audio_reset_n, e_run);
    chk({tag, ".pll_ok"}, pll_ok, e_run);
    chk({tag, ".fault"}, fault, e_flt);
    chk({tag, ".retry"}, retry_count, e_retry);
    chk({tag, ".llc"}, lock_loss_count, e_llc);
  endtask

  always @(negedge clk) begin
    chk("rst_arn_exclusive", pll_rst & audio_reset_n, 0);
    if (audio_reset_n) chk("arn_needs_run_and_lock", {pll_ok, h2}, 2'b11);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic lvl);
    reset_n    = 1'b0;
    restart    = 1'b0;
    pll_locked = lvl;
    tick(3);
    reset_n = 1'b1;
  endtask

  // From cycle 0 of a reset pulse: lock raised at lock_at, RUN one cycle after STAB stable cycles.
  task automatic seq_check(input int lock_at, input int ncyc, input int llc_exp, input string tag);
    int run_at;
    run_at = (((lock_at + 2) > RST) ? (lock_at + 2) : RST) + STAB + 1;
    for (int c = 0; c < ncyc; c++) begin
      if (c == lock_at) pll_locked = 1'b1;
      chk_outs($sformatf("%s@%0d", tag, c), c < RST, c >= run_at, 1'b0, 0, llc_exp);
      tick(1);
    end
  endtask

  task automatic wait_ok(input int bound, input string tag);
    int k;
    k = 0;
    while (!pll_ok && k < bound) begin
      tick(1);
      k++;
    end
    chk(tag, pll_ok, 1);
  endtask

  initial begin
    int lk, gl, run_at, att;
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    restart    = 1'b0;

    do_reset(1'b0);
    chk_outs("reset_values", 1'b1, 1'b0, 1'b0, 0, 0);
    seq_check(10, 35, 0, "normal_l10");
    for (int i = 0; i < 4; i++) begin
      do_reset(1'b0);
      lk = $urandom_range(0, 60);
      seq_check(lk, lk + 25, 0, $sformatf("normal_l%0d", lk));
    end
    // Lock arriving on the final timeout cycle must win over the timeout.
    do_reset(1'b0);
    seq_check(TO + RST - 3, TO + RST + STAB + 5, 0, "lock_vs_timeout");

    do_reset(1'b0);
    for (int c = 0; c < 2 * ATT + 8; c++) begin
      att = c / ATT;
      chk_outs($sformatf("never_lock@%0d", c), (att >= 2) || ((c % ATT) < RST), 1'b0,
               att >= 2, (att > 2) ? 2 : att, 0);
      tick(1);
    end
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    for (int c = 0; c < RST + 2; c++) begin
      chk_outs($sformatf("fault_restart@%0d", c), c < RST, 1'b0, 1'b0, 0, 0);
      tick(1);
    end

    for (int i = 0; i < 3; i++) begin
      do_reset(1'b0);
      lk = (i == 0) ? 10 : $urandom_range(4, 20);
      gl = (i == 0) ? 10 : $urandom_range(1, 15);
      run_at = lk + gl + STAB + 4;
      for (int c = 0; c < run_at + 5; c++) begin
        pll_locked = (c >= lk) && (c != lk + gl);
        chk_outs($sformatf("glitch_l%0d_g%0d@%0d", lk, gl, c), c < RST, c >= run_at, 1'b0, 0, 0);
        tick(1);
      end
    end

    tick($urandom_range(0, 5));
    pll_locked = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_outs($sformatf("loss_lag@%0d", k), 1'b0, 1'b1, 1'b0, 0, 0);
      tick(1);
    end
    seq_check(0, 25, 1, "loss_reseq");

    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      tick(1);
      pll_locked = 1'b1;
      tick(3);
      wait_ok(60, $sformatf("loss_loop_ok%0d", i));
      chk($sformatf("loss_loop_llc%0d", i), lock_loss_count, ((i + 2) > 255) ? 255 : (i + 2));
    end

    do_reset(1'b1);
    seq_check(0, 25, 0, "to_run");
    pll_locked = 1'b0;
    tick(2);
    restart = 1'b1;
    tick(1);
    restart    = 1'b0;
    seq_check(0, 25, 1, "restart_with_loss");
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    seq_check(0, 25, 1, "restart_in_run");

    reset_n = 1'b0;
    restart = 1'b1;
    tick(1);
    chk_outs("reset_in_run", 1'b1, 1'b0, 1'b0, 0, 0);
    reset_n = 1'b1;
    restart = 1'b0;
    seq_check(0, 25, 0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mixer_audio_pll_sequencer.md
MIXER_AUDIO_PLL_SEQUENCER -- requirements
Module: mixer_audio_pll_sequencer

Interface
REQ-001 The block SHALL have parameter RST_CYCLES, default 16, giving the PLL reset pulse length in clk cycles (minimum 2).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 50000, giving the maximum number of cycles spent waiting for lock per attempt.
REQ-003 The block SHALL have parameter STABLE_CYCLES, default 1024, giving the number of consecutive locked cycles required before release.
REQ-004 The block SHALL have parameter MAX_RETRIES, default 3, giving the number of timed-out attempts allowed before FAULT.
REQ-005 Port clk, input, 1 bit: 50 MHz reference clock, the same clock that drives the PLL refclk.
REQ-006 Port reset_n, input, 1 bit: reset, synchronous to clk and active-low.
REQ-007 Port pll_locked, input, 1 bit: raw locked output of the audio PLL, asynchronous.
REQ-008 Port restart, input, 1 bit: single-cycle request to re-initialise the PLL.
REQ-009 Port pll_rst, output, 1 bit: active-high reset to the PLL rst pin.
REQ-010 Port audio_reset_n, output, 1 bit: active-low reset for the 18.432 MHz audio domain; it is high only in RUN.
REQ-011 Port pll_ok, output, 1 bit: high when the state is RUN.
REQ-012 Port fault, output, 1 bit: high when the state is FAULT.
REQ-013 Port retry_count, output, 2 bits: number of timed-out attempts in the current sequence.
REQ-014 Port lock_loss_count, output, 8 bits: saturating count of lock losses detected in RUN.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer before any use; the synchronized signal is lock_s, and lock_s lags pll_locked by 2 cycles.
REQ-016 The FSM SHALL have exactly five states: RESET_PLL, WAIT_LOCK, STABLE_CHECK, RUN, FAULT.
REQ-017 In RESET_PLL, pll_rst=1 for exactly RST_CYCLES cycles, then the FSM SHALL move to WAIT_LOCK with the cycle counter cleared.
REQ-018 In WAIT_LOCK, pll_rst=0; lock_s=1 SHALL cause a move to STABLE_CHECK with the counter cleared.
REQ-019 In WAIT_LOCK, if the counter reaches LOCK_TIMEOUT-1 with lock_s=0, retry_count SHALL increment and the FSM SHALL move to RESET_PLL, or to FAULT if the incremented value equals MAX_RETRIES.
REQ-020 If lock_s and the timeout occur in the same cycle, lock SHALL win.
REQ-021 In STABLE_CHECK, lock_s=0 on any cycle SHALL return the FSM to WAIT_LOCK with the counter cleared; the timeout for that attempt restarts and retry_count is unchanged.
REQ-022 In STABLE_CHECK, after STABLE_CYCLES consecutive cycles with lock_s=1 the FSM SHALL enter RUN; audio_reset_n and pll_ok rise on the entry edge and retry_count clears.
REQ-023 In RUN, lock_s=0 SHALL cause, on the next edge: state RESET_PLL, pll_rst=1, audio_reset_n=0, and lock_loss_count incremented, saturating at 255.
REQ-024 From raw pll_locked falling to audio_reset_n=0 SHALL take exactly 3 cycles.
REQ-025 restart=1 in any state SHALL move the FSM to RESET_PLL on the next edge and clear retry_count.
REQ-026 When restart coincides with lock loss in RUN, the transition SHALL happen once and lock_loss_count SHALL still increment.
REQ-027 FAULT SHALL hold pll_rst=1 and audio_reset_n=0, and SHALL exit only on restart or reset.
REQ-028 All outputs SHALL be registered; no output may be driven combinationally from the inputs.
REQ-029 The cycle counter SHALL be sized to cover the largest of RST_CYCLES, LOCK_TIMEOUT and STABLE_CYCLES, and SHALL never wrap inside any state.

Reset
REQ-030 While reset_n=0 at a clk edge, the block SHALL set: state RESET_PLL with the counter at 0, pll_rst=1, audio_reset_n=0, pll_ok=0, fault=0, retry_count=0, lock_loss_count=0, and synchronizer flops at 0.
REQ-031 Reset asserted mid-operation, including in RUN, SHALL take effect on the next edge with the values above; the RST_CYCLES pulse restarts after reset_n rises.
REQ-032 Reset SHALL override restart.

Structure
REQ-033 Package mixer_audio_pll_pkg SHALL hold the state enum typedef and the default parameter constants.
REQ-034 The synchronizer SHALL be a separate sub-module, mixer_sync2, a generic 2-flop synchronizer with reset-to-0; all other logic SHALL stay in a single module.

Verification
Bench parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=16, MAX_RETRIES=2.
REQ-035 Normal start: release reset, raise pll_locked at cycle 10 -> pll_rst high for cycles 0-3; pll_ok=1 and audio_reset_n=1 at cycle 10+2+16+1; lock_loss_count=0.
REQ-036 Never lock: hold pll_locked=0 -> two timeouts, retry_count goes 1 then 2, fault=1 after 2x(4+100) cycles, pll_rst=1; a restart pulse then gives fault=0, retry_count=0, and a new 4-cycle pll_rst pulse.
REQ-037 Glitchy lock: pll_locked high 10 cycles, low 1, then high -> the FSM returns to WAIT_LOCK, RUN is entered only after 16 uninterrupted lock_s cycles, and retry_count=0.
REQ-038 Lock loss in RUN: drop pll_locked -> audio_reset_n=0 exactly 3 cycles later, lock_loss_count=1, and full re-sequence to RUN; after 300 forced losses lock_loss_count=255.
REQ-039 Corner cases: restart coincident with lock loss -> one RESET_PLL entry and lock_loss_count +1; reset_n=0 asserted in RUN -> all outputs at reset values on the next edge.
REQ-040 Assertions: audio_reset_n=1 implies state RUN and lock_s=1 on the previous cycle; pll_rst and audio_reset_n are never both high.
